fir_tap_sequencer: RTL

Circular-buffer sample sequencer for FIR filtering. It writes each accepted input sample into an internal `dpram` delay line, then streams the most recent TAPS samples, newest first, with a tap index to the downstream multiply-accumulate stage. After reset the delay line is zero-filled, so the first outputs never carry stale RAM contents.

---
 rtl/fir_pkg.sv | 17 +
 rtl/dpram.sv | 29 ++
 rtl/fir_tap_sequencer.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR datapath: sequencer state encoding and the
// tap-index width helper used by the sequencer, coefficient ROM and MAC.
package fir_pkg;

    typedef logic [1:0] state_t;

    localparam state_t CLEAR = 2'd0;
    localparam state_t IDLE  = 2'd1;
    localparam state_t READ  = 2'd2;
    localparam state_t DRAIN = 2'd3;

    // Width of a tap index for a filter of 'taps' taps, never less than one bit.
    function automatic int tap_width(input int taps);
        return (taps <= 2) ? 1 : $clog2(taps);
    endfunction

endpackage

// File: rtl/dpram.sv
// Simple dual-port RAM: one synchronous write port, one registered read port.
// Contents are not reset; the sequencer zero-fills it after reset.
module dpram #(
    parameter int BITS   = 16,
    parameter int SIZE   = 256,
    parameter int AWIDTH = $clog2(SIZE)
) (
    input  logic              ck,
    input  logic              we,
    input  logic [AWIDTH-1:0] waddr,
    input  logic [BITS-1:0]   wdata,
    input  logic              re,
    input  logic [AWIDTH-1:0] raddr,
    output logic [BITS-1:0]   rdata
);

    logic [BITS-1:0] mem [SIZE];

    // Write port
    always_ff @(posedge ck) begin
        if (we) mem[waddr] <= wdata;
    end

    // Registered read port; data appears the cycle after re
    always_ff @(posedge ck) begin
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/fir_tap_sequencer.sv
// Circular-buffer tap sequencer for an FIR filter. Each accepted sample is
// written into a delay line, then the newest TAPS samples are streamed out
// newest first with their tap index. The delay line is zero-filled after reset.
// Optional feature: define FIR_TAP_SEQUENCER_OVERRUN_EN to add the sticky
// 'overrun' output flagging samples dropped while busy.
//
// Handshake: in_valid is a one-cycle strobe accepted only when busy=0; there
// is no backpressure on the output side -- out_valid marks each tap word and
// the downstream stage must take it in that cycle.
module fir_tap_sequencer
    import fir_pkg::*;
#(
    parameter int BITS   = 16,
    parameter int SIZE   = 256,
    parameter int TAPS   = 32,
    parameter int AWIDTH = $clog2(SIZE),
    parameter int TWIDTH = tap_width(TAPS)
) (
    input  logic              ck,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [BITS-1:0]   in_data,
    output logic              busy,
    output logic              out_valid,
    output logic [BITS-1:0]   out_data,
    output logic [TWIDTH-1:0] out_tap,
    output logic              out_last
`ifdef FIR_TAP_SEQUENCER_OVERRUN_EN
    ,
    output logic              overrun
`endif
);

    localparam logic [AWIDTH-1:0] A_ONE  = 1;
    localparam logic [TWIDTH-1:0] T_ONE  = 1;
    localparam logic [AWIDTH-1:0] A_LAST = AWIDTH'(SIZE - 1);
    localparam logic [TWIDTH-1:0] T_LAST = TWIDTH'(TAPS - 1);

    state_t state, state_nx;

    logic [AWIDTH-1:0] wptr;
    logic [AWIDTH-1:0] base;
    logic [AWIDTH-1:0] clr_addr;
    logic [TWIDTH-1:0] k;

    logic              we;
    logic [AWIDTH-1:0] waddr;
    logic [BITS-1:0]   wdata;
    logic              re;
    logic [AWIDTH-1:0] raddr;
    logic [BITS-1:0]   rdata;

    logic              rd_valid;
    logic [TWIDTH-1:0] tap_q;
    logic              last_q;

    logic accept;
    logic k_last;
    logic clr_last;

    assign accept   = (state == IDLE) && in_valid;
    assign k_last   = (k == T_LAST);
    assign clr_last = (clr_addr == A_LAST);

    // State register; reset always restarts the zero-fill
    always_ff @(posedge ck) begin
        if (rst) state <= CLEAR;
        else     state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            CLEAR:   if (clr_last) state_nx = IDLE;
            IDLE:    if (in_valid) state_nx = READ;
            READ:    if (k_last)   state_nx = DRAIN;
            DRAIN:   state_nx = IDLE;
            default: state_nx = CLEAR;
        endcase
    end

    // RAM port control and busy, decoded from state
    always_comb begin
        busy  = (state != IDLE);
        we    = 1'b0;
        waddr = wptr;
        wdata = in_data;
        re    = 1'b0;
        raddr = base - AWIDTH'(k);
        case (state)
            CLEAR: begin
                we    = 1'b1;
                waddr = clr_addr;
                wdata = '0;
            end
            IDLE:    we = in_valid;
            READ:    re = 1'b1;
            default: ;
        endcase
    end

    // Pointers and tap counter; addresses wrap naturally at AWIDTH bits
    always_ff @(posedge ck) begin
        if (rst) begin
            wptr     <= '0;
            base     <= '0;
            clr_addr <= '0;
            k        <= '0;
        end else begin
            if (state == CLEAR) clr_addr <= clr_addr + A_ONE;
            if (accept) begin
                base <= wptr;
                wptr <= wptr + A_ONE;
                k    <= '0;
            end
            if (state == READ) k <= k + T_ONE;
        end
    end

    // Tag each read with its tap index so it lines up with the RAM output
    always_ff @(posedge ck) begin
        if (rst) begin
            rd_valid <= 1'b0;
            tap_q    <= '0;
            last_q   <= 1'b0;
        end else begin
            rd_valid <= re;
            tap_q    <= re ? k : '0;
            last_q   <= re && k_last;
        end
    end

    assign out_valid = rd_valid;
    assign out_tap   = tap_q;
    assign out_last  = last_q;
    // RAM output register is not reset, so hold data low outside valid words
    assign out_data  = rd_valid ? rdata : '0;

`ifdef FIR_TAP_SEQUENCER_OVERRUN_EN
    // Sticky flag for any strobe that arrived while busy
    always_ff @(posedge ck) begin
        if (rst)                   overrun <= 1'b0;
        else if (in_valid && busy) overrun <= 1'b1;
    end
`endif

    dpram #(
        .BITS   (BITS),
        .SIZE   (SIZE),
        .AWIDTH (AWIDTH)
    ) u_ram (
        .ck    (ck),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .re    (re),
        .raddr (raddr),
        .rdata (rdata)
    );

endmodule
